// File: rtl/lcd_timing_gen.sv
// RGB-panel timing generator: HSYNC/VSYNC/DE, pixel request coordinates and gated pixel bus,
// with per-panel timing selected from the panel ID.
module lcd_timing_gen #(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic [15:0]       lcd_id,
  input  logic [DATA_W-1:0] pixel_data,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic [CNT_W-1:0]  h_disp,
  output logic [CNT_W-1:0]  v_disp,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_bl,
  output logic              lcd_rst
);

  logic [CNT_W-1:0] w_hs, w_hb, w_hd, w_ht;
  logic [CNT_W-1:0] w_vs, w_vb, w_vd, w_vt;

  always_comb begin
    w_hs = CNT_W'(41);  w_hb = CNT_W'(2);  w_hd = CNT_W'(480);  w_ht = CNT_W'(525);
    w_vs = CNT_W'(10);  w_vb = CNT_W'(2);  w_vd = CNT_W'(272);  w_vt = CNT_W'(286);
    unique case (lcd_id)
      16'h7084, 16'h4384: begin
        w_hs = CNT_W'(128); w_hb = CNT_W'(88);  w_hd = CNT_W'(800);  w_ht = CNT_W'(1056);
        w_vs = CNT_W'(2);   w_vb = CNT_W'(33);  w_vd = CNT_W'(480);  w_vt = CNT_W'(525);
      end
      16'h7016: begin
        w_hs = CNT_W'(20);  w_hb = CNT_W'(140); w_hd = CNT_W'(1024); w_ht = CNT_W'(1344);
        w_vs = CNT_W'(3);   w_vb = CNT_W'(20);  w_vd = CNT_W'(600);  w_vt = CNT_W'(635);
      end
      16'h1018: begin
        w_hs = CNT_W'(10);  w_hb = CNT_W'(80);  w_hd = CNT_W'(1280); w_ht = CNT_W'(1440);
        w_vs = CNT_W'(3);   w_vb = CNT_W'(10);  w_vd = CNT_W'(800);  w_vt = CNT_W'(823);
      end
      default: ;
    endcase
  end

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [15:0]      r_id_q;
  logic             r_bl, r_rst;

  // An ID change restarts the frame from (0,0) rather than carrying a partial frame over.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_id_q  <= lcd_id;
      r_bl    <= 1'b0;
      r_rst   <= 1'b0;
    end else begin
      r_bl   <= 1'b1;
      r_rst  <= 1'b1;
      r_id_q <= lcd_id;
      if (lcd_id != r_id_q) begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end else if (r_h_cnt >= w_ht - CNT_W'(1)) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt >= w_vt - CNT_W'(1)) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  logic [CNT_W-1:0] w_h_start, w_h_end, w_v_start, w_v_end;
  logic             w_v_act, w_de, w_req;

  assign w_h_start = w_hs + w_hb;
  assign w_h_end   = w_hs + w_hb + w_hd - CNT_W'(1);
  assign w_v_start = w_vs + w_vb;
  assign w_v_end   = w_vs + w_vb + w_vd - CNT_W'(1);

  assign w_v_act = (r_v_cnt >= w_v_start) && (r_v_cnt <= w_v_end);
  assign w_de    = w_v_act && (r_h_cnt >= w_h_start) && (r_h_cnt <= w_h_end);
  // Request runs one cycle ahead of DE to absorb the upstream pixel latency.
  assign w_req   = w_v_act && (r_h_cnt >= w_h_start - CNT_W'(1)) &&
                   (r_h_cnt <= w_h_end - CNT_W'(1));

  assign pixel_xpos = w_req ? r_h_cnt - (w_h_start - CNT_W'(1)) : '0;
  assign pixel_ypos = w_req ? r_v_cnt - w_v_start : '0;
  assign h_disp     = w_hd;
  assign v_disp     = w_vd;
  assign lcd_hs     = (r_h_cnt >= w_hs);
  assign lcd_vs     = (r_v_cnt >= w_vs);
  assign lcd_de     = w_de;
  assign lcd_rgb    = w_de ? pixel_data : '0;
  assign lcd_bl     = r_bl;
  assign lcd_rst    = r_rst;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: ID table vectors, a frame-position reference model checked every
// cycle, and directed sequences for reset, ID switching and line/frame structure.
module tb_lcd_timing_gen;
  localparam int CNT_W  = 11;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       lcd_id;
  logic [DATA_W-1:0] pixel_data;
  logic [CNT_W-1:0]  pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic              lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst;
  logic [DATA_W-1:0] lcd_rgb;

  lcd_timing_gen #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .lcd_pclk   (clk),
    .rst_n      (rst_n),
    .lcd_id     (lcd_id),
    .pixel_data (pixel_data),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_rgb    (lcd_rgb),
    .lcd_bl     (lcd_bl),
    .lcd_rst    (lcd_rst)
  );

  always #5 clk = ~clk;

  typedef struct {int hs, hb, hd, ht, vs, vb, vd, vt;} tim_t;
  typedef struct {logic [15:0] id; int hd; int vd;} vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_t;        // pclk edges since the last frame restart
  logic [15:0] m_idq;
  bit          m_started;
  logic [10:0] prev_x, prev_y;

  function automatic tim_t tab(input logic [15:0] id);
    tim_t t;
    case (id)
      16'h7084, 16'h4384: t = '{128, 88, 800, 1056, 2, 33, 480, 525};
      16'h7016:           t = '{20, 140, 1024, 1344, 3, 20, 600, 635};
      16'h1018:           t = '{10, 80, 1280, 1440, 3, 10, 800, 823};
      default:            t = '{41, 2, 480, 525, 10, 2, 272, 286};
    endcase
    return t;
  endfunction

  function automatic logic [15:0] pat(input logic [10:0] x, input logic [10:0] y);
    return {x[4:0], y[5:0], x[4:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d id=%h)", name, act, exp, m_t, lcd_id);
    end
  endtask

  // Expected outputs from the frame position implied by m_t.
  task automatic check_all();
    tim_t p;
    int h, v, ex, ey, erg;
    bit vact, de, req;
    p    = tab(lcd_id);
    h    = m_t % p.ht;
    v    = (m_t / p.ht) % p.vt;
    vact = (v >= p.vs + p.vb) && (v < p.vs + p.vb + p.vd);
    de   = vact && (h >= p.hs + p.hb) && (h < p.hs + p.hb + p.hd);
    req  = vact && (h >= p.hs + p.hb - 1) && (h < p.hs + p.hb + p.hd - 1);
    ex   = req ? h - (p.hs + p.hb - 1) : 0;
    ey   = req ? v - (p.vs + p.vb) : 0;
    erg  = de ? int'(pat(11'(h - (p.hs + p.hb)), 11'(v - (p.vs + p.vb)))) : 0;
    chk("hs",   32'(lcd_hs),     32'(h >= p.hs));
    chk("vs",   32'(lcd_vs),     32'(v >= p.vs));
    chk("de",   32'(lcd_de),     32'(de));
    chk("xpos", 32'(pixel_xpos), 32'(ex));
    chk("ypos", 32'(pixel_ypos), 32'(ey));
    chk("rgb",  32'(lcd_rgb),    32'(erg));
    chk("bl",   32'(lcd_bl),     32'(m_started));
    chk("rst",  32'(lcd_rst),    32'(m_started));
  endtask

  // One pclk: upstream answers the previous cycle's request, then all outputs are checked.
  task automatic step();
    @(posedge clk);
    m_started = 1'b1;
    if (lcd_id != m_idq) begin
      m_t   = 0;
      m_idq = lcd_id;
    end else begin
      m_t++;
    end
    #1 pixel_data = pat(prev_x, prev_y);
    #1 check_all();
    prev_x = pixel_xpos;
    prev_y = pixel_ypos;
  endtask

  task automatic do_reset(input logic [15:0] id);
    lcd_id = id;
    #1 rst_n = 1'b0;
    #1;
    m_t       = 0;
    m_started = 1'b0;
    m_idq     = lcd_id;
    prev_x    = '0;
    prev_y    = '0;
    check_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  vec_t        vecs[7];
  logic [15:0] ids[6];

  initial begin
    int cnt, run, hs_low, vs_low, de_tot;
    bit seen_high;
    rst_n      = 1'b0;
    lcd_id     = 16'h4342;
    pixel_data = '0;
    m_t        = 0;
    m_idq      = lcd_id;
    m_started  = 1'b0;
    prev_x     = '0;
    prev_y     = '0;

    vecs[0] = '{16'h4342, 480, 272};
    vecs[1] = '{16'h7084, 800, 480};
    vecs[2] = '{16'h7016, 1024, 600};
    vecs[3] = '{16'h4384, 800, 480};
    vecs[4] = '{16'h1018, 1280, 800};
    vecs[5] = '{16'h1234, 480, 272};
    vecs[6] = '{16'hffff, 480, 272};
    for (int i = 0; i < 7; i++) begin
      lcd_id = vecs[i].id;
      #3;
      chk("h_disp", 32'(h_disp), 32'(vecs[i].hd));
      chk("v_disp", 32'(v_disp), 32'(vecs[i].vd));
      m_idq = lcd_id;
      check_all();
    end

    // 4342 from reset: first DE at line 12, h 43; 480-wide active run; async reset mid-line.
    do_reset(16'h4342);
    cnt = 0;
    do begin step(); cnt++; end while (!lcd_de && cnt < 7000);
    chk("first_de_cycle", 32'(cnt), 32'(12 * 525 + 43));
    run = 0;
    while (lcd_de && run < 1000) begin run++; step(); end
    chk("de_run_4342", 32'(run), 32'd480);
    repeat (100) step();
    chk("de_before_reset", 32'(lcd_de), 32'd1);
    do_reset(16'h4342);
    chk("bl_in_reset", 32'(lcd_bl), 32'd0);
    chk("rst_in_reset", 32'(lcd_rst), 32'd0);
    chk("de_in_reset", 32'(lcd_de), 32'd0);

    // Unknown ID follows the 4342 timing.
    do_reset(16'h1234);
    cnt = 0;
    do begin step(); cnt++; end while (!lcd_de && cnt < 7000);
    chk("first_de_1234", 32'(cnt), 32'(12 * 525 + 43));

    // 7084: 37 lines of sync/DE accounting (edges t=1..37*1056).
    do_reset(16'h7084);
    hs_low = 0; vs_low = 0; de_tot = 0; run = 0; cnt = 0;
    for (int i = 0; i < 37 * 1056; i++) begin
      step();
      if (!lcd_hs) hs_low++;
      if (!lcd_vs) vs_low++;
      if (lcd_de) begin
        de_tot++;
        run++;
      end else if (run != 0) begin
        chk("de_run_7084", 32'(run), 32'd800);
        run = 0;
        cnt++;
      end
    end
    chk("hs_low_7084", 32'(hs_low), 32'(37 * 128));
    chk("vs_low_7084", 32'(vs_low), 32'(2 * 1056 - 1));
    chk("de_total_7084", 32'(de_tot), 32'(2 * 800));
    chk("de_lines_7084", 32'(cnt), 32'd2);

    // ID switch mid-line restarts at (0,0) with the new 1344-cycle line.
    do_reset(16'h4342);
    repeat (200) step();
    lcd_id = 16'h7016;
    step();
    chk("hs_after_switch", 32'(lcd_hs), 32'd0);
    chk("vs_after_switch", 32'(lcd_vs), 32'd0);
    cnt = 0;
    seen_high = 1'b0;
    while (cnt < 2000) begin
      step();
      cnt++;
      if (lcd_hs) seen_high = 1'b1;
      else if (seen_high) break;
    end
    chk("line_period_7016", 32'(cnt), 32'd1344);

    // Random schedule of resets, ID switches and run lengths.
    ids = '{16'h4342, 16'h7084, 16'h7016, 16'h4384, 16'h1018, 16'h0000};
    for (int s = 0; s < 6; s++) begin
      logic [15:0] nid;
      nid = ids[$urandom_range(0, 5)];
      if (nid == 16'h0000) nid = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       do_reset(nid);
        1:       lcd_id = nid;
        default: ;
      endcase
      repeat ($urandom_range(300, 2500)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not reach its summary (tests=%0d failed=%0d)",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule
